// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit add/subtract, DIGIT bits per cycle through a registered carry.
// Latency NUM_STEPS=WIDTH/DIGIT cycles from acceptance to out_valid; in_ready only when idle,
// result held until out_ready. Optional overflow output: define MULTICYCLE_ADDER_OVERFLOW_EN.
module multicycle_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NUM_STEPS = WIDTH / DIGIT;
  localparam int CW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             c;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dadd;
  logic [WIDTH-1:0] res_next;
  logic             last_step;
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
  logic             msb_cin;
`endif

  always_comb begin
    dadd      = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
    // Each new digit enters at the top, so after NUM_STEPS steps res is in bit order.
    res_next  = (res >> DIGIT) | (WIDTH'(dadd[DIGIT-1:0]) << (WIDTH - DIGIT));
    last_step = (cnt == CW'(NUM_STEPS - 1));
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
    msb_cin   = opa[DIGIT-1] ^ opb[DIGIT-1] ^ dadd[DIGIT-1];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      res       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract as a + ~b + ~borrow_in.
            opa      <= a;
            opb      <= sub ? ~b : b;
            c        <= carry_in ^ sub;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          res <= res_next;
          opa <= opa >> DIGIT;
          opb <= opb >> DIGIT;
          c   <= dadd[DIGIT];
          cnt <= cnt + 1'b1;
          if (last_step) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= res_next;
            carry_out <= dadd[DIGIT];
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
            overflow  <= msb_cin ^ dadd[DIGIT];
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
